// File: rtl/branch_predictor_if.sv
// Fetch/Execute signal bundle between the pipeline and the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] PCF;
  logic             PredTakenF;
  logic [WIDTH-1:0] PredTargetF;
  logic             UpdateE;
  logic             BranchE;
  logic             TakenE;
  logic [WIDTH-1:0] PCE;
  logic [WIDTH-1:0] TargetE;
  logic             PredTakenE;
  logic [WIDTH-1:0] PredTargetE;
  logic             MispredictE;
  logic [WIDTH-1:0] CorrectPCE;
  logic [31:0]      BranchCnt;
  logic [31:0]      MispredCnt;

  modport master (
    output PCF, UpdateE, BranchE, TakenE, PCE, TargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, CorrectPCE, BranchCnt, MispredCnt
  );

  modport slave (
    input  PCF, UpdateE, BranchE, TakenE, PCE, TargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, CorrectPCE, BranchCnt, MispredCnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit saturating counters. Combinational
// fetch lookup, Execute-stage mispredict detection and training.
module branch_predictor #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8,
  parameter int WIDTH   = 32
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 2 ** INDEX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [WIDTH-1:0]   target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [31:0]        branch_cnt_q;
  logic [31:0]        mispred_cnt_q;

  logic [INDEX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]   tag_f, tag_e;
  logic               hit_f, hit_e;
  logic               mispredict;
  logic               train;
  logic               unused_pcf_bits;

  assign idx_f = bp.PCF[INDEX_W+1:2];
  assign tag_f = bp.PCF[INDEX_W+TAG_W+1:INDEX_W+2];
  assign idx_e = bp.PCE[INDEX_W+1:2];
  assign tag_e = bp.PCE[INDEX_W+TAG_W+1:INDEX_W+2];
  assign unused_pcf_bits = ^{bp.PCF[1:0], bp.PCF[WIDTH-1:INDEX_W+TAG_W+2]};

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign train = bp.UpdateE && bp.BranchE;

  always_comb begin
    bp.PredTakenF  = 1'b0;
    bp.PredTargetF = '0;
    if (hit_f) begin
      bp.PredTakenF  = ctr_q[idx_f][1];
      bp.PredTargetF = target_q[idx_f];
    end
  end

  // A predicted-taken non-branch means the BTB aliased onto it.
  always_comb begin
    mispredict = 1'b0;
    if (bp.UpdateE) begin
      if (bp.BranchE) begin
        if (bp.TakenE != bp.PredTakenE)
          mispredict = 1'b1;
        else if (bp.TakenE && (bp.TargetE != bp.PredTargetE))
          mispredict = 1'b1;
      end else if (bp.PredTakenE) begin
        mispredict = 1'b1;
      end
    end
  end

  assign bp.MispredictE = mispredict;
  assign bp.CorrectPCE  = (bp.BranchE && bp.TakenE) ? bp.TargetE
                                                    : bp.PCE + WIDTH'(4);
  assign bp.BranchCnt   = branch_cnt_q;
  assign bp.MispredCnt  = mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '0;
      tag_q         <= '{default: '0};
      target_q      <= '{default: '0};
      ctr_q         <= '{default: 2'b01};
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (train) begin
        if (hit_e) begin
          if (bp.TakenE) begin
            if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
            target_q[idx_e] <= bp.TargetE;
          end else if (ctr_q[idx_e] != 2'b00) begin
            ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
          end
        end else if (bp.TakenE) begin
          valid_q[idx_e]  <= 1'b1;
          tag_q[idx_e]    <= tag_e;
          target_q[idx_e] <= bp.TargetE;
          ctr_q[idx_e]    <= 2'b10;
        end
      end else if (bp.UpdateE && bp.PredTakenE && hit_e) begin
        valid_q[idx_e] <= 1'b0;
      end

      if (train && (branch_cnt_q != '1))
        branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict && (mispred_cnt_q != '1))
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end
endmodule
